// File: rtl/uart_cmd_controller_pkg.sv
// Shared definitions for the UART command-frame controller.
// Holds the start-of-frame marker, the 3-bit state encodings (also exported
// on debug_state) and width helpers for the timeout counter and payload
// address.
package uart_ctrl_pkg;

  localparam logic [7:0] SOF = 8'hA5;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CMD      = 3'd1;
  localparam logic [2:0] S_LEN      = 3'd2;
  localparam logic [2:0] S_PAYLOAD  = 3'd3;
  localparam logic [2:0] S_CHK      = 3'd4;
  localparam logic [2:0] S_DISPATCH = 3'd5;

  // Bits needed to count from 0 up to cycles-1.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

  // Payload address width; never collapses to zero bits.
  function automatic int addr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/uart_cmd_controller_if.sv
// Receiver-side and consumer-side handshake bundle of uart_cmd_controller.
//   rx_data/rx_valid/rx_read_en : byte stream from uart_receiver
//   cmd_valid/cmd_ready         : validated-command handshake
//   cmd_code/cmd_len            : held command byte and payload length
//   pl_addr/pl_data             : combinational payload buffer read port
// master = controller view, slave = surrounding logic (receiver + consumer).
interface uart_cmd_controller_if #(
  parameter int MAX_PAYLOAD = 16
);
  localparam int AW = uart_ctrl_pkg::addr_width(MAX_PAYLOAD);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_read_en;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_code;
  logic [7:0]    cmd_len;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_data;

  modport master (
    input  rx_data, rx_valid, cmd_ready, pl_addr,
    output rx_read_en, cmd_valid, cmd_code, cmd_len, pl_data
  );

  modport slave (
    output rx_data, rx_valid, cmd_ready, pl_addr,
    input  rx_read_en, cmd_valid, cmd_code, cmd_len, pl_data
  );

endinterface

// File: rtl/uart_cmd_controller_frame_timer.sv
// Inter-byte gap timer.
//   clk, reset : clock and synchronous active-high reset
//   clear      : restart the count from zero
//   expired    : count has reached CYCLES-1 (holds there until cleared)
module frame_timer
  import uart_ctrl_pkg::*;
#(
  parameter int CYCLES = 10000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expired
);
  localparam int W = cnt_width(CYCLES);

  logic [W-1:0] count;

  assign expired = (count == W'(CYCLES - 1));

  // Holding at the terminal value keeps the counter from wrapping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_controller.sv
// Frame parser between uart_receiver and the command dispatcher.
// Parses SOF, CMD, LEN, payload, CHK (XOR of CMD, LEN and payload), holds a
// validated command until the consumer accepts it, and reports length,
// checksum and inter-byte timeout errors as one-cycle pulses.
//   clk, reset   : clock and synchronous active-high reset
//   bus          : receiver/consumer handshake bundle (master modport)
//   busy         : not idle
//   err_checksum : frame checksum mismatch pulse
//   err_len      : LEN above MAX_PAYLOAD pulse
//   err_timeout  : inter-byte gap expired pulse
//   debug_state  : current state encoding
module uart_cmd_controller
  import uart_ctrl_pkg::*;
#(
  parameter int CLK_FREQ    = 1_000_000,
  parameter int MAX_PAYLOAD = 16,
  parameter int TIMEOUT_MS  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_cmd_controller_if.master bus,
  output logic                  busy,
  output logic                  err_checksum,
  output logic                  err_len,
  output logic                  err_timeout,
  output logic [2:0]            debug_state
);
  localparam int         TIMEOUT_CYCLES = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int         AW             = addr_width(MAX_PAYLOAD);
  localparam int         DEPTH          = 1 << AW;
  localparam logic [7:0] MAX_LEN        = 8'(MAX_PAYLOAD);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       consume;
  logic       in_frame;
  logic       expired;
  logic       len_bad;
  logic       chk_ok;
  logic       last_pl;
  logic [7:0] chk;
  logic [7:0] idx;
  logic [7:0] buffer [DEPTH];

  // While a command is held the receiver is back-pressured, and the cycle
  // carrying the acknowledge never takes a second byte.
  assign consume  = bus.rx_valid && !bus.rx_read_en && (state != S_DISPATCH);
  assign in_frame = state inside {S_CMD, S_LEN, S_PAYLOAD, S_CHK};
  assign len_bad  = bus.rx_data > MAX_LEN;
  assign chk_ok   = bus.rx_data == chk;
  assign last_pl  = idx == (bus.cmd_len - 8'd1);
  assign bus.pl_data = buffer[bus.pl_addr];

  frame_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (consume || state == S_IDLE || state == S_DISPATCH),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (consume && bus.rx_data == SOF) state_nxt = S_CMD;
      S_CMD:      if (consume) state_nxt = S_LEN;
      S_LEN:      if (consume) state_nxt = len_bad ? S_IDLE :
                                           (bus.rx_data != 8'd0) ? S_PAYLOAD : S_CHK;
      S_PAYLOAD:  if (consume && last_pl) state_nxt = S_CHK;
      S_CHK:      if (consume) state_nxt = chk_ok ? S_DISPATCH : S_IDLE;
      S_DISPATCH: if (bus.cmd_ready) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    // A byte arriving in the expiry cycle takes priority over the timeout.
    if (in_frame && expired && !consume) state_nxt = S_IDLE;
  end

  always_comb begin
    busy          = state != S_IDLE;
    debug_state   = state;
    bus.cmd_valid = state == S_DISPATCH;
  end

  // Control registers: acknowledge, error pulses, held command header.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rx_read_en <= 1'b0;
      err_len        <= 1'b0;
      err_checksum   <= 1'b0;
      err_timeout    <= 1'b0;
      bus.cmd_code   <= 8'd0;
      bus.cmd_len    <= 8'd0;
    end else begin
      bus.rx_read_en <= consume;
      err_len        <= consume && state == S_LEN && len_bad;
      err_checksum   <= consume && state == S_CHK && !chk_ok;
      err_timeout    <= !consume && expired && in_frame;
      if (consume && state == S_CMD) bus.cmd_code <= bus.rx_data;
      if (consume && state == S_LEN && !len_bad) bus.cmd_len <= bus.rx_data;
    end
  end

  // Datapath: running checksum, payload index and buffer are re-initialised
  // by each frame, so they carry no reset.
  always_ff @(posedge clk) begin
    if (consume) begin
      case (state)
        S_IDLE: if (bus.rx_data == SOF) chk <= 8'd0;
        S_CMD:  chk <= chk ^ bus.rx_data;
        S_LEN:
          if (!len_bad) begin
            chk <= chk ^ bus.rx_data;
            idx <= 8'd0;
          end
        S_PAYLOAD: begin
          buffer[idx[AW-1:0]] <= bus.rx_data;
          chk                 <= chk ^ bus.rx_data;
          idx                 <= idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Scoreboard bench for uart_cmd_controller: each frame pushes its expected
// outcome (command with payload, or error kind); outcomes are popped and
// compared as the DUT presents them.
module tb_uart_cmd_controller;
  import uart_ctrl_pkg::*;

  localparam int CLK_FREQ    = 100_000;
  localparam int MAX_PAYLOAD = 16;
  localparam int TIMEOUT_MS  = 1;
  localparam int TMO         = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int AW          = $clog2(MAX_PAYLOAD);

  localparam logic [2:0] K_NONE = 3'd0;
  localparam logic [2:0] K_CMD  = 3'd1;
  localparam logic [2:0] K_CHK  = 3'd2;
  localparam logic [2:0] K_LEN  = 3'd3;
  localparam logic [2:0] K_TMO  = 3'd4;

  typedef struct packed {
    logic [2:0]       kind;
    logic [7:0]       code;
    logic [7:0]       len;
    logic [15:0][7:0] pl;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic       err_checksum;
  logic       err_len;
  logic       err_timeout;
  logic [2:0] debug_state;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] f[$];
  int         lat;

  uart_cmd_controller_if #(.MAX_PAYLOAD(MAX_PAYLOAD)) bus ();

  uart_cmd_controller #(
    .CLK_FREQ    (CLK_FREQ),
    .MAX_PAYLOAD (MAX_PAYLOAD),
    .TIMEOUT_MS  (TIMEOUT_MS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .err_checksum (err_checksum),
    .err_len      (err_len),
    .err_timeout  (err_timeout),
    .debug_state  (debug_state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xor_chk(input logic [7:0] q[$]);
    logic [7:0] c = 8'd0;
    for (int i = 1; i < q.size(); i++) c ^= q[i];
    return c;
  endfunction

  task automatic push_cmd(input logic [7:0] q[$]);
    exp_t e;
    e      = '0;
    e.kind = K_CMD;
    e.code = q[1];
    e.len  = q[2];
    for (int i = 0; i < int'(q[2]); i++) e.pl[i] = q[3+i];
    sb.push_back(e);
  endtask

  task automatic push_err(input logic [2:0] k);
    exp_t e;
    e      = '0;
    e.kind = k;
    sb.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.rx_read_en && n < 50);
    check_val("byte_ack", 32'(bus.rx_read_en), 1);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic expect_event(output int latency);
    int         n = 0;
    exp_t       e;
    logic [2:0] k;
    while (!(bus.cmd_valid || err_checksum || err_len || err_timeout) && n < TMO + 20) begin
      @(posedge clk); #1;
      n++;
    end
    latency = n;
    k = bus.cmd_valid ? K_CMD : err_checksum ? K_CHK : err_len ? K_LEN :
        err_timeout ? K_TMO : K_NONE;
    check_val("sb_has_entry", 32'(sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check_val("event_kind", 32'(k), 32'(e.kind));
    if (k == K_CMD && e.kind == K_CMD) begin
      check_val("cmd_code", 32'(bus.cmd_code), 32'(e.code));
      check_val("cmd_len", 32'(bus.cmd_len), 32'(e.len));
      for (int i = 0; i < int'(e.len); i++) begin
        bus.pl_addr = AW'(i);
        #1;
        check_val($sformatf("pl[%0d]", i), 32'(bus.pl_data), 32'(e.pl[i]));
      end
    end else if (k != K_NONE) begin
      @(posedge clk); #1;
      check_val("err_pulse_width", 32'({err_checksum, err_len, err_timeout}), 0);
      check_val("state_after_err", 32'(debug_state), 32'(S_IDLE));
      check_val("no_cmd_after_err", 32'(bus.cmd_valid), 0);
    end
  endtask

  task automatic accept();
    bus.cmd_ready = 1'b1;
    @(posedge clk); #1;
    check_val("accept_cmd_valid", 32'(bus.cmd_valid), 0);
    check_val("accept_state", 32'(debug_state), 32'(S_IDLE));
    bus.cmd_ready = 1'b0;
  endtask

  task automatic expect_quiet(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
      check_val("quiet", 32'({bus.cmd_valid, err_checksum, err_len, err_timeout, busy}), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    bus.rx_data   = 8'd0;
    bus.rx_valid  = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.pl_addr   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_rx_read_en", 32'(bus.rx_read_en), 0);
    check_val("rst_cmd_valid", 32'(bus.cmd_valid), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_errs", 32'({err_checksum, err_len, err_timeout}), 0);
    check_val("rst_cmd_code", 32'(bus.cmd_code), 0);
    check_val("rst_cmd_len", 32'(bus.cmd_len), 0);
    check_val("rst_debug_state", 32'(debug_state), 0);
    reset = 1'b0;

    // Two-byte payload, then hold the command with cmd_ready low.
    f = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44};
    f.push_back(xor_chk(f));
    push_cmd(f);
    send_frame(f);
    expect_event(lat);
    bus.rx_data  = 8'h5A;
    bus.rx_valid = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check_val("bp_rx_read_en", 32'(bus.rx_read_en), 0);
      check_val("bp_state", 32'(debug_state), 32'(S_DISPATCH));
      check_val("bp_cmd_valid", 32'(bus.cmd_valid), 1);
    end
    bus.rx_valid = 1'b0;
    accept();

    // Zero-length payload.
    f = '{8'hA5, 8'h20, 8'h00};
    f.push_back(xor_chk(f));
    push_cmd(f);
    send_frame(f);
    expect_event(lat);
    accept();

    // Wrong checksum byte.
    f = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h00};
    push_err(K_CHK);
    send_frame(f);
    expect_event(lat);

    // LEN = MAX_PAYLOAD+1, then trailing bytes are dropped in idle.
    f = '{8'hA5, 8'h10, 8'h11};
    push_err(K_LEN);
    send_frame(f);
    expect_event(lat);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h00);
    expect_quiet(3);

    // Silence mid-payload: timeout fires TMO cycles after the last byte.
    f = '{8'hA5, 8'h10, 8'h02, 8'h33};
    push_err(K_TMO);
    send_frame(f);
    expect_event(lat);
    check_val("timeout_latency", 32'(lat), 32'(TMO));
    send_byte(8'h00);
    send_byte(8'hFF);
    expect_quiet(3);

    // Reset mid-payload aborts silently; next frame is received.
    f = '{8'hA5, 8'h10, 8'h03, 8'h11};
    send_frame(f);
    check_val("mid_state", 32'(debug_state), 32'(S_PAYLOAD));
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("mrst_busy", 32'(busy), 0);
    check_val("mrst_state", 32'(debug_state), 32'(S_IDLE));
    check_val("mrst_code_len", 32'({bus.cmd_code, bus.cmd_len}), 0);
    check_val("mrst_outs", 32'({bus.rx_read_en, bus.cmd_valid, err_checksum, err_len, err_timeout}), 0);
    reset = 1'b0;
    f = '{8'hA5, 8'h30, 8'h03, 8'h01, 8'h02, 8'h03};
    f.push_back(xor_chk(f));
    push_cmd(f);
    send_frame(f);
    expect_event(lat);
    accept();

    // Full 16-byte payload with an embedded SOF value treated as data.
    f = '{8'hA5, 8'h42, 8'h10};
    for (int i = 0; i < 16; i++) f.push_back((i == 3) ? 8'hA5 : 8'(i * 37 + 5));
    f.push_back(xor_chk(f));
    push_cmd(f);
    send_frame(f);
    expect_event(lat);
    accept();

    check_val("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
